// File: rtl/if_id_fifo.sv
// Fetch->decode instruction queue with a show-ahead head: 1-cycle latency, 0 with IF_ID_FIFO_BYPASS_EN.
// Backpressure: in_ready drops only when full (never depends on out_ready); flush empties it in one cycle.
module if_id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_pc,
  input  logic [WIDTH-1:0]         in_inst,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_pc,
  output logic [WIDTH-1:0]         out_inst,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] inst;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          empty;
  logic          byp;
  logic          push;
  logic          pop;
  logic          wr_en;
  logic          rd_en;

  assign empty    = (cnt == '0);
  assign in_ready = (cnt != FULL);
  assign head     = mem[rd_ptr];
  assign count    = cnt;

`ifdef IF_ID_FIFO_BYPASS_EN
  // Gated by rst so the outputs stay zero while reset is held.
  assign byp = rst & empty & in_valid & ~flush;
`else
  assign byp = 1'b0;
`endif

  always_comb begin
    out_valid = 1'b0;
    out_pc    = '0;
    out_inst  = '0;
    if (!empty) begin
      out_valid = ~flush;
      out_pc    = head.pc;
      out_inst  = head.inst;
    end else if (byp) begin
      out_valid = 1'b1;
      out_pc    = in_pc;
      out_inst  = in_inst;
    end
  end

  assign push  = in_valid & in_ready & ~flush;
  assign pop   = out_valid & out_ready & ~flush;
  // A bypassed pair consumed the same cycle never touches storage.
  assign wr_en = push & ~(byp & out_ready);
  assign rd_en = pop & ~empty;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= entry_t'({in_pc, in_inst});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_fifo.sv
// Bench for if_id_fifo: table of per-cycle vectors plus hand sequences; head data checked via a scoreboard queue.
module tb_if_id_fifo;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] sb [$];

  typedef struct {
    bit          iv;
    bit          ordy;
    bit          fl;
    logic [31:0] pc;
    logic [31:0] inst;
    int          cnt;
    bit          rdy;
    bit          vld;
  } vec_t;

  vec_t tbl [20];

  if_id_fifo #(.DEPTH(4), .WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit iv, bit ordy, bit fl, logic [31:0] pc, int cnt, bit rdy, bit vld);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.pc = pc;
    v.inst = 32'hE1A0_0000 + pc;
    v.cnt = cnt; v.rdy = rdy; v.vld = vld;
    return v;
  endfunction

  // One clock: drive, check mid-cycle against expectations, update scoreboard, advance.
  task automatic cycle(input bit iv, input bit ordy, input bit fl, input logic [31:0] pc,
                       input logic [31:0] inst, input int ecnt, input bit erdy, input bit evld);
    bit ev;
    bit eat;
    logic [63:0] exp_head;
    ev = evld;
`ifdef IF_ID_FIFO_BYPASS_EN
    if (ecnt == 0 && iv && !fl) ev = 1'b1;
`endif
    in_valid = iv; out_ready = ordy; flush = fl; in_pc = pc; in_inst = inst;
    #3;
    chk("count", 64'(count), 64'(ecnt));
    chk("in_ready", 64'(in_ready), 64'(erdy));
    chk("out_valid", 64'(out_valid), 64'(ev));
    if (ev) begin
      exp_head = (sb.size() > 0) ? sb[0] : {pc, inst};
      chk("head_pc", 64'(out_pc), 64'(exp_head[63:32]));
      chk("head_inst", 64'(out_inst), 64'(exp_head[31:0]));
    end else if (ecnt == 0) begin
      chk("empty_pc_zero", 64'(out_pc), 64'd0);
      chk("empty_inst_zero", 64'(out_inst), 64'd0);
    end
    if (fl) begin
      sb.delete();
    end else begin
      eat = ev && ordy && (sb.size() == 0);
      if (ev && ordy && sb.size() > 0) void'(sb.pop_front());
      if (iv && erdy && !eat) sb.push_back({pc, inst});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_pc = '0; in_inst = '0;

    // Fill under freeze, drain in order
    tbl[0]  = mk(1, 0, 0,  4, 0, 1, 0);
    tbl[1]  = mk(1, 0, 0,  8, 1, 1, 1);
    tbl[2]  = mk(1, 0, 0, 12, 2, 1, 1);
    tbl[3]  = mk(1, 0, 0, 16, 3, 1, 1);
    tbl[4]  = mk(1, 0, 0, 20, 4, 0, 1);
    tbl[5]  = mk(0, 1, 0,  0, 4, 0, 1);
    tbl[6]  = mk(0, 1, 0,  0, 3, 1, 1);
    tbl[7]  = mk(0, 1, 0,  0, 2, 1, 1);
    tbl[8]  = mk(0, 1, 0,  0, 1, 1, 1);
    tbl[9]  = mk(0, 0, 0,  0, 0, 1, 0);
    // Refill, then full with simultaneous pop: push refused
    tbl[10] = mk(1, 0, 0, 24, 0, 1, 0);
    tbl[11] = mk(1, 0, 0, 28, 1, 1, 1);
    tbl[12] = mk(1, 0, 0, 32, 2, 1, 1);
    tbl[13] = mk(1, 0, 0, 36, 3, 1, 1);
    tbl[14] = mk(1, 1, 0, 40, 4, 0, 1);
    tbl[15] = mk(0, 0, 0,  0, 3, 1, 1);
    // Flush with push and pop requested, then the branch-target fetch
    tbl[16] = mk(1, 1, 1, 44, 3, 1, 0);
    tbl[17] = mk(1, 0, 0, 116, 0, 1, 0);
    tbl[17].inst = 32'hEA00_0010;
    tbl[18] = mk(0, 1, 0,  0, 1, 1, 1);
    tbl[19] = mk(0, 0, 0,  0, 0, 1, 0);

    #3;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_out_inst", 64'(out_inst), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i < 20; i++)
      cycle(tbl[i].iv, tbl[i].ordy, tbl[i].fl, tbl[i].pc, tbl[i].inst,
            tbl[i].cnt, tbl[i].rdy, tbl[i].vld);

    // Streaming with wrap: PC 4..40 with decode never stalled
    for (int i = 0; i < 12; i++) begin
      logic [31:0] p;
      p = 32'(4 * (i + 1));
`ifdef IF_ID_FIFO_BYPASS_EN
      cycle(i < 10, 1, 0, p, 32'hE280_0000 + p, 0, 1, 0);
`else
      cycle(i < 10, 1, 0, p, 32'hE280_0000 + p,
            (i == 0 || i == 11) ? 0 : 1, 1, (i != 0 && i != 11));
`endif
    end
    chk("stream_sb_empty", 64'(sb.size()), 64'd0);

    // Empty queue, decode ready: same-cycle bypass or one-cycle latency
`ifdef IF_ID_FIFO_BYPASS_EN
    cycle(1, 1, 0, 32'd200, 32'hE084_4003, 0, 1, 1);
    cycle(0, 0, 0, 32'd0, 32'd0, 0, 1, 0);
`else
    cycle(1, 1, 0, 32'd200, 32'hE084_4003, 0, 1, 0);
    cycle(0, 1, 0, 32'd0, 32'd0, 1, 1, 1);
    cycle(0, 0, 0, 32'd0, 32'd0, 0, 1, 0);
`endif

    // Asynchronous reset mid-stream with three entries queued
    cycle(1, 0, 0, 32'd60, 32'hE1A0_003C, 0, 1, 0);
    cycle(1, 0, 0, 32'd64, 32'hE1A0_0040, 1, 1, 1);
    cycle(1, 0, 0, 32'd68, 32'hE1A0_0044, 2, 1, 1);
    in_valid = 1'b0;
    #2;
    chk("pre_rst_count", 64'(count), 64'd3);
    rst = 1'b0;
    #1;
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_out_inst", 64'(out_inst), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle(1, 0, 0, 32'd4, 32'hE3A0_0014, 0, 1, 0);
    cycle(0, 1, 0, 32'd0, 32'd0, 1, 1, 1);
    cycle(0, 0, 0, 32'd0, 32'd0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
